// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS sequencer FSM with shared memory port, retire counter and halt/timeout handling
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
                         MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
                         ADDIEX = 4'd10, ADDIWB = 4'd11, HALT = 4'd12;
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd6, ALU_SLT = 4'd7;
  logic [3:0] next_state;
  logic [31:0] wait_cnt;
  logic err_set, wait_st, tmo, retire, fn_ok;
  logic [5:0] opc, fn;
  logic [3:0] fn_op;
  assign opc = instr[31:26];
  assign fn = instr[5:0];
  assign fn_op = fn == 6'h20 ? ALU_ADD : fn == 6'h22 ? ALU_SUB : fn == 6'h24 ? ALU_AND :
                 fn == 6'h25 ? ALU_OR : ALU_SLT;
  assign fn_ok = fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  assign wait_st = state == FETCH || state == MEMRD || state == MEMWR;
  assign tmo = TIMEOUT != 0 && wait_st && !mem_ready && wait_cnt == 32'(TIMEOUT - 1);
  assign retire = next_state == FETCH && (state == MEMWB || state == MEMWR || state == ALUWB ||
                  state == BRANCH || state == JUMP || state == ADDIWB);
  assign halted = state == HALT;
  // next-state selection, with memory timeout overriding any transition
  always_comb begin
    next_state = state;
    err_set = 1'b0;
    case (state)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (instr == 32'd0) next_state = HALT;
        else if (opc == 6'h00) next_state = EXEC;
        else if (opc == 6'h23 || opc == 6'h2B) next_state = MEMADR;
        else if (opc == 6'h04 || opc == 6'h05) next_state = BRANCH;
        else if (opc == 6'h02) next_state = JUMP;
        else if (opc == 6'h08) next_state = ADDIEX;
        else begin
          next_state = HALT;
          err_set = 1'b1;
        end
      end
      MEMADR: next_state = opc == 6'h2B ? MEMWR : MEMRD;
      MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
      MEMWR:  next_state = mem_ready ? FETCH : MEMWR;
      EXEC:   begin
        next_state = fn_ok ? ALUWB : HALT;
        err_set = !fn_ok;
      end
      ADDIEX: next_state = ADDIWB;
      HALT:   next_state = HALT;
      default: next_state = FETCH;
    endcase
    if (tmo) begin
      next_state = HALT;
      err_set = 1'b1;
    end
  end
  // datapath controls decoded from the current state, forced low while in reset
  always_comb begin
    pc_write = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 4'd0;
    pc_source = 2'b00;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'b01;
          alu_op = ALU_ADD;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          alu_op = ALU_ADD;
        end
        MEMADR, ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op = ALU_ADD;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord = 1'b1;
        end
        MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          iord = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op = fn_ok ? fn_op : 4'd0;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = ALU_SUB;
          pc_source = 2'b01;
          pc_write = opc == 6'h05 ? !zero : zero;
        end
        JUMP: begin
          pc_source = 2'b10;
          pc_write = 1'b1;
        end
        ADDIWB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end
  // state, memory wait counter, sticky error and saturating retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      wait_cnt <= 32'd0;
      error <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      wait_cnt <= (wait_st && !mem_ready && !tmo) ? wait_cnt + 32'd1 : 32'd0;
      if (err_set) error <= 1'b1;
      if (retire && !(&instr_count)) instr_count <= instr_count + CNT_W'(1);
    end
  end
endmodule
